// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared branch condition codes and compare-mode selectors.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam logic [2:0] COND_ZERO = 3'b000;
  localparam logic [2:0] COND_NZ   = 3'b001;
  localparam logic [2:0] COND_POS  = 3'b010;
  localparam logic [2:0] COND_NEG  = 3'b011;
  localparam logic [2:0] COND_GEZ  = 3'b100;
  localparam logic [2:0] COND_LEZ  = 3'b101;
  // Codes 110/111 mean always/never in single mode, unsigned GT/LT in pair mode
  localparam logic [2:0] COND_ALW  = 3'b110;
  localparam logic [2:0] COND_GTU  = 3'b110;
  localparam logic [2:0] COND_NEV  = 3'b111;
  localparam logic [2:0] COND_LTU  = 3'b111;

  localparam logic CMP_SINGLE = 1'b0;
  localparam logic CMP_PAIR   = 1'b1;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/branch_condition_unit_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Combinational branch condition evaluator (bus vs 0 or A vs bus).
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cmp_mode,
  input  logic [2:0]            cond,
  output logic                  taken
);

  logic [DATA_WIDTH-1:0] w_lhs;
  logic [DATA_WIDTH-1:0] w_rhs;

  // Single mode is bus-vs-zero, so both modes share the same signed comparators
  always_comb begin
    w_lhs = (cmp_mode == CMP_PAIR) ? a : b;
    w_rhs = (cmp_mode == CMP_PAIR) ? b : '0;
    taken = 1'b0;
    case (cond)
      COND_ZERO: taken = (w_lhs == w_rhs);
      COND_NZ:   taken = (w_lhs != w_rhs);
      COND_POS:  taken = ($signed(w_lhs) >  $signed(w_rhs));
      COND_NEG:  taken = ($signed(w_lhs) <  $signed(w_rhs));
      COND_GEZ:  taken = ($signed(w_lhs) >= $signed(w_rhs));
      COND_LEZ:  taken = ($signed(w_lhs) <= $signed(w_rhs));
      COND_GTU:  taken = (cmp_mode == CMP_PAIR) ? (w_lhs > w_rhs) : 1'b1;
      COND_LTU:  taken = (cmp_mode == CMP_PAIR) ? (w_lhs < w_rhs) : 1'b0;
    endcase
  end

endmodule : cond_eval
`default_nettype wire

// File: rtl/branch_condition_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_condition_unit
// Description : Registered branch condition unit with operand A register,
//               optional input stage and CON flip-flop.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_condition_unit
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] bus_data,
  input  logic                  ld_a,
  input  logic                  a_clr,
  input  logic                  eval,
  input  logic                  cmp_mode,
  input  logic [2:0]            cond,
  output logic                  con_out,
  output logic                  con_valid,
  output logic                  a_valid,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] r_a;
  logic                  r_a_valid;

  logic                  w_eval;
  logic                  w_cmp_mode;
  logic [2:0]            w_cond;
  logic [DATA_WIDTH-1:0] w_bus;
  logic [DATA_WIDTH-1:0] w_a;
  logic                  w_a_ok;
  logic                  w_taken;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_a       <= '0;
      r_a_valid <= 1'b0;
    end else if (ld_a) begin
      r_a       <= bus_data;
      r_a_valid <= 1'b1;
    end else if (a_clr) begin
      r_a_valid <= 1'b0;
    end
  end

  assign a_valid = r_a_valid;

  // The stage captures A and a_valid too, so a same-cycle ld_a/a_clr sees old values
  generate
    if (LATENCY == 2) begin : g_stage
      logic                  r_s_eval;
      logic                  r_s_cmp_mode;
      logic [2:0]            r_s_cond;
      logic [DATA_WIDTH-1:0] r_s_bus;
      logic [DATA_WIDTH-1:0] r_s_a;
      logic                  r_s_a_ok;

      always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
          r_s_eval     <= 1'b0;
          r_s_cmp_mode <= 1'b0;
          r_s_cond     <= 3'b000;
          r_s_bus      <= '0;
          r_s_a        <= '0;
          r_s_a_ok     <= 1'b0;
        end else begin
          r_s_eval     <= eval;
          r_s_cmp_mode <= cmp_mode;
          r_s_cond     <= cond;
          r_s_bus      <= bus_data;
          r_s_a        <= r_a;
          r_s_a_ok     <= r_a_valid;
        end
      end

      assign w_eval     = r_s_eval;
      assign w_cmp_mode = r_s_cmp_mode;
      assign w_cond     = r_s_cond;
      assign w_bus      = r_s_bus;
      assign w_a        = r_s_a;
      assign w_a_ok     = r_s_a_ok;
    end else begin : g_direct
      assign w_eval     = eval;
      assign w_cmp_mode = cmp_mode;
      assign w_cond     = cond;
      assign w_bus      = bus_data;
      assign w_a        = r_a;
      assign w_a_ok     = r_a_valid;
    end
  endgenerate

  cond_eval #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cond_eval (
    .a        (w_a),
    .b        (w_bus),
    .cmp_mode (w_cmp_mode),
    .cond     (w_cond),
    .taken    (w_taken)
  );

  logic w_missing_a;
  assign w_missing_a = (w_cmp_mode == CMP_PAIR) && !w_a_ok;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      con_out   <= 1'b0;
      con_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      con_valid <= w_eval;
      err       <= w_eval && w_missing_a;
      if (w_eval) begin
        con_out <= w_missing_a ? 1'b0 : w_taken;
      end
    end
  end

endmodule : branch_condition_unit
`default_nettype wire
